// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one shared memory port, data first.
// Optional one-entry fetch buffer enabled by defining MEM_ARB_IBUF_EN.
module mem_port_arbiter #(
  parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        INSTR_MEM_READ,
  input  logic [31:0] PC,
  output logic [31:0] INSTRUCTION,
  output logic        INSTR_MEM_BUSYWAIT,
  input  logic [3:0]  DATA_MEM_READ,
  input  logic [2:0]  DATA_MEM_WRITE,
  input  logic [31:0] DATA_MEM_ADDR,
  input  logic [31:0] DATA_MEM_WRITE_DATA,
  output logic [31:0] DATA_MEM_READ_DATA,
  output logic        DATA_MEM_BUSYWAIT,
  output logic [3:0]  MEM_READ,
  output logic [2:0]  MEM_WRITE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WRITE_DATA,
  input  logic [31:0] MEM_READ_DATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [2:0] {
    IDLE,
    DATA_ACC,
    INSTR_ACC,
    DATA_RESP,
    INSTR_RESP
  } state_t;

  localparam logic [3:0] LW_CMD = 4'b1010;

  state_t      state;
  state_t      state_next;
  logic        dreq;
  logic        ireq;
  logic        hit;
  logic [31:0] instr_q;

  assign dreq = DATA_MEM_READ[3] | DATA_MEM_WRITE[2];
  assign ireq = INSTR_MEM_READ;

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE: begin
        if (dreq)             state_next = DATA_ACC;
        else if (ireq & ~hit) state_next = INSTR_ACC;
      end
      DATA_ACC:   if (!MEM_BUSYWAIT) state_next = DATA_RESP;
      INSTR_ACC:  if (!MEM_BUSYWAIT) state_next = INSTR_RESP;
      DATA_RESP:  state_next = IDLE;
      INSTR_RESP: state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state              <= IDLE;
      MEM_READ           <= '0;
      MEM_WRITE          <= '0;
      MEM_ADDR           <= '0;
      MEM_WRITE_DATA     <= '0;
      DATA_MEM_READ_DATA <= '0;
      instr_q            <= RESET_INSTR;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (dreq) begin
            // A simultaneous load and store enable performs the store only.
            if (DATA_MEM_WRITE[2]) begin
              MEM_READ  <= '0;
              MEM_WRITE <= DATA_MEM_WRITE;
            end else begin
              MEM_READ  <= DATA_MEM_READ;
              MEM_WRITE <= '0;
            end
            MEM_ADDR       <= DATA_MEM_ADDR;
            MEM_WRITE_DATA <= DATA_MEM_WRITE_DATA;
          end else if (ireq & ~hit) begin
            MEM_READ  <= LW_CMD;
            MEM_WRITE <= '0;
            MEM_ADDR  <= PC;
          end
        end
        DATA_ACC: begin
          if (!MEM_BUSYWAIT) begin
            MEM_READ  <= '0;
            MEM_WRITE <= '0;
            if (MEM_READ[3]) DATA_MEM_READ_DATA <= MEM_READ_DATA;
          end
        end
        INSTR_ACC: begin
          if (!MEM_BUSYWAIT) begin
            MEM_READ  <= '0;
            MEM_WRITE <= '0;
            instr_q   <= MEM_READ_DATA;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ARB_IBUF_EN
  logic        buf_valid;
  logic [29:0] buf_tag;
  logic [31:0] buf_word;
  logic        wr_to_tag;

  // A store in flight to the buffered word makes the entry stale before it completes.
  assign wr_to_tag = (state == DATA_ACC) & MEM_WRITE[2] & (MEM_ADDR[31:2] == buf_tag);
  assign hit       = buf_valid & (buf_tag == PC[31:2]) & ~wr_to_tag;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      buf_valid <= 1'b0;
    end else if ((state == INSTR_ACC) && !MEM_BUSYWAIT) begin
      buf_valid <= 1'b1;
    end else if (wr_to_tag && !MEM_BUSYWAIT) begin
      buf_valid <= 1'b0;
    end
  end

  // NOTE: tag and word need no reset; they are never used while buf_valid is low.
  always_ff @(posedge CLK) begin
    if ((state == INSTR_ACC) && !MEM_BUSYWAIT) begin
      buf_tag  <= MEM_ADDR[31:2];
      buf_word <= MEM_READ_DATA;
    end
  end

  assign INSTRUCTION = hit ? buf_word : instr_q;
`else
  assign hit         = 1'b0;
  assign INSTRUCTION = instr_q;
`endif

  assign DATA_MEM_BUSYWAIT  = dreq & (state != DATA_RESP);
  assign INSTR_MEM_BUSYWAIT = ireq & ~hit & (state != INSTR_RESP);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one backing memory port between the CPU instruction-fetch port and the CPU data-memory port. It sequences each access as a single transaction on the shared port and returns the result to the requester. It generates `INSTR_MEM_BUSYWAIT` and `DATA_MEM_BUSYWAIT` for the CPU. It sits between the `cpu` top-level memory ports and the unified memory model or cache.

## Interface

Parameters:
- `RESET_INSTR`, default `32'h00000013`: value of `INSTRUCTION` after reset (NOP).

Ports. Reset is synchronous, active-high.
- `CLK`  in  1  clock; all state changes on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `INSTR_MEM_READ`  in  1  fetch request, held high while fetching
- `PC`  in  32  fetch address, word-aligned
- `INSTRUCTION`  out  32  fetched word
- `INSTR_MEM_BUSYWAIT`  out  1  fetch stall
- `DATA_MEM_READ`  in  4  bit 3 = load enable; bits [2:0] = funct3
- `DATA_MEM_WRITE`  in  3  bit 2 = store enable; bits [1:0] = size
- `DATA_MEM_ADDR`  in  32  data address
- `DATA_MEM_WRITE_DATA`  in  32  store data
- `DATA_MEM_READ_DATA`  out  32  load result
- `DATA_MEM_BUSYWAIT`  out  1  data stall
- `MEM_READ`  out  4  shared-port read command; same encoding as `DATA_MEM_READ`
- `MEM_WRITE`  out  3  shared-port write command; same encoding as `DATA_MEM_WRITE`
- `MEM_ADDR`  out  32  shared-port address
- `MEM_WRITE_DATA`  out  32  shared-port write data
- `MEM_READ_DATA`  in  32  shared-port read data
- `MEM_BUSYWAIT`  in  1  memory not ready

## Operation

- Request definitions:
  - Data request (`dreq`) = `DATA_MEM_READ[3] | DATA_MEM_WRITE[2]`.
  - Instruction request (`ireq`) = `INSTR_MEM_READ`.
  - If both `DATA_MEM_READ[3]` and `DATA_MEM_WRITE[2]` are high, the write is performed.
- FSM states:
  - `IDLE`, `DATA_ACC`, `INSTR_ACC`, `DATA_RESP`, `INSTR_RESP`.
- `IDLE` transitions:
  - `dreq` → `DATA_ACC`.
  - Else `ireq` → `INSTR_ACC`.
  - Else stay in `IDLE`.
  - Priority is fixed: data first.
- On entering `DATA_ACC`, the following are registered from the data port:
  - `MEM_READ` / `MEM_WRITE` / `MEM_ADDR` / `MEM_WRITE_DATA`.
- On entering `INSTR_ACC`, the following are registered:
  - `MEM_READ=4'b1010` (LW).
  - `MEM_WRITE=0`.
  - `MEM_ADDR=PC`.
- Access completion:
  - An access completes at the first rising edge in an `_ACC` state with `MEM_BUSYWAIT=0`.
  - At that edge, `MEM_READ` / `MEM_WRITE` clear.
  - `MEM_READ_DATA` is latched into `DATA_MEM_READ_DATA` for a data read, or into `INSTRUCTION` for a fetch.
  - For a data write, `DATA_MEM_READ_DATA` is unchanged.
  - The FSM then moves to the matching `_RESP` state.
- `_RESP` lasts exactly one cycle, then returns to `IDLE`.
- Busywait outputs (combinational):
  - `DATA_MEM_BUSYWAIT = dreq & (state != DATA_RESP)`.
  - `INSTR_MEM_BUSYWAIT = ireq & (state != INSTR_RESP)` (hit term added under Configuration).
- Requester inputs are sampled only on entry to `_ACC`. Changes during `_ACC` are ignored.
- A requester still asserting the same request after its `_RESP` cycle, because the CPU is stalled by the other port, is re-issued. Loads and stores are idempotent, so this is allowed.
- Reset values:
  - State `IDLE`.
  - `MEM_READ=0`, `MEM_WRITE=0`.
  - `MEM_ADDR=0`, `MEM_WRITE_DATA=0`.
  - `DATA_MEM_READ_DATA=0`.
  - `INSTRUCTION=RESET_INSTR`.
- Busywaits have no register. They follow requests immediately after reset.
- Reset mid-transaction:
  - The shared-port transaction is abandoned.
  - `MEM_READ` and `MEM_WRITE` are 0 in the cycle after the `RESET` edge.
  - No partial latch of read data.

## Timing

- Miss latency with `MEM_BUSYWAIT` low, request first seen in cycle 0:
  - Cycle 0: the FSM is in `IDLE`.
  - Cycle 1: the shared-port command is driven.
  - Cycle 2: the response is valid and the requester's busywait is low.
  - The requester advances at the end of cycle 2.
  - Busywait is high for 2 cycles.
- Each memory wait cycle adds 1 cycle.
- Both requests in cycle 0: the data access finishes in cycle 2 and the fetch finishes in cycle 5.
- The shared port carries at most one outstanding transaction. There is never a command in `IDLE` or `_RESP`.

## Configuration

- Macro: `MEM_ARB_IBUF_EN`.
- Enabled: adds a one-entry fetch buffer.
  - Entry fields: valid bit, tag `PC[31:2]`, 32-bit word.
  - Filled on every `INSTR_ACC` completion.
- Hit condition: `hit = valid & tag==PC[31:2]`.
  - On a hit, `INSTRUCTION` = buffered word.
  - `INSTR_MEM_BUSYWAIT = ireq & ~hit & (state != INSTR_RESP)`.
  - A hit never starts an access.
- Invalidation:
  - Cleared by `RESET`.
  - Cleared by a completing data write with `MEM_ADDR[31:2]==tag`.
  - Hit is suppressed during `DATA_ACC` holding a write to the tagged word.
- Disabled: no buffer. Every fetch goes to the shared port.

## Test plan

- Fetch only:
  - Stimulus: `PC=0x40`, `MEM_READ_DATA=0x00300193`, `MEM_BUSYWAIT=0`.
  - Cycle 1: `MEM_READ=1010`, `MEM_ADDR=0x40`.
  - `INSTR_MEM_BUSYWAIT` high in cycles 0–1.
  - Cycle 2: busywait low and `INSTRUCTION=0x00300193`.
- Simultaneous requests:
  - Stimulus: `PC=0x44`, `DATA_MEM_READ=1010`, `DATA_MEM_ADDR=0x100`.
  - `MEM_ADDR=0x100` in cycle 1, `0x44` in cycle 4.
  - `DATA_MEM_BUSYWAIT` low in cycle 2.
  - `INSTR_MEM_BUSYWAIT` low in cycle 5.
- Slow store:
  - Stimulus: `DATA_MEM_WRITE=101`, `DATA_MEM_ADDR=0x200`, `DATA_MEM_WRITE_DATA=0xBEEF`, `MEM_BUSYWAIT` high for 3 cycles.
  - `MEM_WRITE=101` held for 4 cycles.
  - `DATA_MEM_BUSYWAIT` low in cycle 5.
  - `DATA_MEM_READ_DATA` unchanged.
- Reset mid-access:
  - Stimulus: `RESET` asserted while in `DATA_ACC`.
  - Next cycle: `MEM_READ=0`, `MEM_WRITE=0`, `INSTRUCTION=0x00000013`, FSM in `IDLE`.
- `MEM_ARB_IBUF_EN`, buffer hit:
  - Stimulus: second fetch of `0x40`.
  - `INSTR_MEM_BUSYWAIT` stays 0.
  - No `MEM_READ`.
- `MEM_ARB_IBUF_EN`, invalidation:
  - Stimulus: `SW` to `0x40`, then fetch `0x40`.
  - The fetch misses and issues `MEM_READ=1010`.
